// File: rtl/tf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tf_pkg
// Brief    : Shared constants and state type for the twiddle-factor sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package tf_pkg;

    localparam int ADDR_ROM_WIDTH = 8;
    localparam int DATA_WIDTH     = 84;
    localparam int DEPTH_ROM      = 213;
    localparam int TF_LANE_W      = 12;
    localparam int TF_LANES       = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tf_state_t;

endpackage
`default_nettype wire

// File: rtl/tf_out_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tf_out_ctrl
// Brief    : Issue counter and valid/last handshake toward the butterfly array.
// Revision : 1.0 - initial release
// ============================================================================
module tf_out_ctrl #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    input  logic [CNT_W-1:0] num_rows,
    input  logic             tf_ready,
    output logic             issue,
    output logic [CNT_W-1:0] k,
    output logic             tf_valid,
    output logic             tf_last,
    output logic             pass_end
);

    // A new read may be launched only when the output register is free or
    // being drained this cycle; otherwise the ROM is frozen to hold Q.
    assign issue    = run && (k < num_rows) && (!tf_valid || tf_ready);
    assign pass_end = run && tf_valid && tf_ready && tf_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k        <= '0;
            tf_valid <= 1'b0;
            tf_last  <= 1'b0;
        end else begin
            if (clr) begin
                k <= '0;
            end else if (issue) begin
                k <= k + CNT_W'(1);
            end
            tf_valid <= issue | (tf_valid & ~tf_ready);
            if (issue) begin
                tf_last <= (k == num_rows - CNT_W'(1));
            end else begin
                tf_last <= tf_valid & ~tf_ready & tf_last;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tf_addr_seq.sv
`default_nettype none
// ============================================================================
// Module   : tf_addr_seq
// Brief    : Twiddle ROM preload and per-pass row-window read sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tf_addr_seq #(
    parameter int ADDR_ROM_WIDTH = tf_pkg::ADDR_ROM_WIDTH,
    parameter int DATA_WIDTH     = tf_pkg::DATA_WIDTH,
    parameter int DEPTH_ROM      = tf_pkg::DEPTH_ROM
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      mode_inv,
    input  logic [ADDR_ROM_WIDTH-1:0] base_addr,
    input  logic [ADDR_ROM_WIDTH:0]   num_rows,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    input  logic                      ld_clr,
    input  logic                      ld_we,
    input  logic [DATA_WIDTH-1:0]     ld_data,
    output logic [ADDR_ROM_WIDTH-1:0] rom_A,
    output logic [DATA_WIDTH-1:0]     rom_D,
    output logic                      rom_EN,
    output logic                      rom_REN,
    input  logic [DATA_WIDTH-1:0]     rom_Q,
    output logic                      tf_valid,
    input  logic                      tf_ready,
    output logic [DATA_WIDTH-1:0]     tf_data,
    output logic                      tf_last
);

    import tf_pkg::*;

    localparam int AW = ADDR_ROM_WIDTH;
    localparam int CW = ADDR_ROM_WIDTH + 1;
    // Window-end sum needs two extra bits: base (AW) plus num_rows (AW+1).
    localparam int XW = ADDR_ROM_WIDTH + 2;

    tf_state_t      state;
    tf_state_t      state_nxt;
    logic [AW-1:0]  ld_ptr;
    logic [AW-1:0]  base_q;
    logic [CW-1:0]  num_q;
    logic           inv_q;
    logic           err_q;
    logic           issue;
    logic           pass_end;
    logic [CW-1:0]  k;
    logic [CW-1:0]  rd_row;
    logic [XW-1:0]  win_end;
    logic           win_ovf;
    logic           win_empty;
    logic           load_go;
    logic           clr_go;
    logic           start_go;

    assign clr_go    = (state == ST_IDLE) && ld_clr;
    assign load_go   = (state == ST_IDLE) && ld_we && !ld_clr;
    assign start_go  = (state == ST_IDLE) && start;
    assign win_end   = XW'(base_addr) + XW'(num_rows);
    assign win_ovf   = win_end > XW'(DEPTH_ROM);
    assign win_empty = (num_rows == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (win_ovf || win_empty) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (pass_end) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            ld_ptr <= '0;
            err_q  <= 1'b0;
            base_q <= '0;
            num_q  <= '0;
            inv_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clr_go) begin
                ld_ptr <= '0;
            end else if (load_go) begin
                ld_ptr <= (ld_ptr == AW'(DEPTH_ROM - 1)) ? '0 : ld_ptr + AW'(1);
            end
            if (start_go && win_ovf) begin
                err_q <= 1'b1;
            end else if (clr_go) begin
                err_q <= 1'b0;
            end
            if (start_go) begin
                base_q <= base_addr;
                num_q  <= num_rows;
                inv_q  <= mode_inv;
            end
        end
    end

    tf_out_ctrl #(
        .CNT_W (CW)
    ) u_out_ctrl (
        .clk      (clk),
        .rst      (rst),
        .run      (state == ST_RUN),
        .clr      (start_go),
        .num_rows (num_q),
        .tf_ready (tf_ready),
        .issue    (issue),
        .k        (k),
        .tf_valid (tf_valid),
        .tf_last  (tf_last),
        .pass_end (pass_end)
    );

    assign rd_row = inv_q ? (CW'(base_q) + num_q - CW'(1) - k) : (CW'(base_q) + k);

    always_comb begin
        rom_EN  = 1'b0;
        rom_REN = 1'b1;
        rom_A   = '0;
        rom_D   = '0;
        if (load_go) begin
            rom_EN  = 1'b1;
            rom_REN = 1'b0;
            rom_A   = ld_ptr;
            rom_D   = ld_data;
        end else if (issue) begin
            rom_EN = 1'b1;
            rom_A  = AW'(rd_row);
        end
    end

    assign busy    = (state == ST_RUN);
    assign done    = (state == ST_DONE);
    assign err     = err_q;
    assign tf_data = rom_Q;

endmodule
`default_nettype wire

// File: tb/tb_tf_addr_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tf_addr_seq
// Brief    : Self-checking bench for tf_addr_seq with a behavioural ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tf_addr_seq;

    localparam int AW    = 8;
    localparam int DW    = 84;
    localparam int DEPTH = 213;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode_inv;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_rows;
    logic          busy;
    logic          done;
    logic          err;
    logic          ld_clr;
    logic          ld_we;
    logic [DW-1:0] ld_data;
    logic [AW-1:0] rom_A;
    logic [DW-1:0] rom_D;
    logic          rom_EN;
    logic          rom_REN;
    logic [DW-1:0] rom_Q;
    logic          tf_valid;
    logic          tf_ready;
    logic [DW-1:0] tf_data;
    logic          tf_last;

    always #5 clk = ~clk;

    tf_addr_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode_inv  (mode_inv),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ld_clr    (ld_clr),
        .ld_we     (ld_we),
        .ld_data   (ld_data),
        .rom_A     (rom_A),
        .rom_D     (rom_D),
        .rom_EN    (rom_EN),
        .rom_REN   (rom_REN),
        .rom_Q     (rom_Q),
        .tf_valid  (tf_valid),
        .tf_ready  (tf_ready),
        .tf_data   (tf_data),
        .tf_last   (tf_last)
    );

    // Twiddle ROM stand-in: registered read, write when REN=0, all gated by EN.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (rom_EN) begin
            if (!rom_REN) begin
                if (int'(rom_A) < DEPTH) mem[rom_A] <= rom_D;
            end else begin
                rom_Q <= (int'(rom_A) < DEPTH) ? mem[rom_A] : '0;
            end
        end
    end

    logic [DW-1:0] ref_mem [DEPTH];
    int            ref_ptr;
    bit            ref_err;
    int            passes;
    int            fails;
    int            checks;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ld_clr = 1'b1;
        step();
        ld_clr  = 1'b0;
        ref_ptr = 0;
        ref_err = 1'b0;
    endtask

    task automatic load(input logic [DW-1:0] d, input bit check_addr);
        ld_we   = 1'b1;
        ld_data = d;
        #1;
        if (check_addr) begin
            chk("ld_A", DW'(rom_A), DW'(ref_ptr));
            chk("ld_REN", DW'(rom_REN), DW'(0));
            chk("ld_EN", DW'(rom_EN), DW'(1));
        end
        ref_mem[ref_ptr] = d;
        ref_ptr = (ref_ptr + 1) % DEPTH;
        step();
        ld_we = 1'b0;
    endtask

    // rmode: 0 = always ready, 1 = random ready, 2 = stall stall_len cycles on beat stall_at
    task automatic run_pass(input int base, input int num, input bit inv, input int rmode,
                            input int stall_at, input int stall_len, input bit noise);
        logic [DW-1:0] q[$];
        int  c;
        int  acc;
        int  stl;
        bit  seen_done;
        bit  ovf;
        ovf = (base + num) > DEPTH;
        if (!ovf) begin
            for (int j = 0; j < num; j++) begin
                q.push_back(ref_mem[inv ? base + num - 1 - j : base + j]);
            end
        end
        if (ovf) ref_err = 1'b1;
        start     = 1'b1;
        base_addr = AW'(base);
        num_rows  = (AW+1)'(num);
        mode_inv  = inv;
        step();
        start = 1'b0;
        c = 0; acc = 0; stl = 0; seen_done = 1'b0;
        while (!seen_done && c < 300) begin
            if (rmode == 1) tf_ready = ($urandom_range(0, 3) != 0);
            else if (rmode == 2 && tf_valid && acc == stall_at && stl < stall_len) begin
                tf_ready = 1'b0;
                stl++;
            end else tf_ready = 1'b1;
            if (noise) begin
                ld_we   = ($urandom_range(0, 1) == 1);
                ld_data = DW'({$urandom(), $urandom(), $urandom()});
            end
            #1;
            if (done) begin
                seen_done = 1'b1;
                ld_we     = 1'b0;
            end else begin
                chk("busy", DW'(busy), DW'(1));
                chk("run_REN", DW'(rom_REN), DW'(1));
                if (c == 0 && num > 0 && !ovf) begin
                    chk("issue_EN", DW'(rom_EN), DW'(1));
                    chk("issue_A", DW'(rom_A), DW'(inv ? base + num - 1 : base));
                    chk("first_lat", DW'(tf_valid), DW'(0));
                end
                if (tf_valid) begin
                    if (q.size() == 0) chk("extra_beat", DW'(1), DW'(0));
                    else begin
                        chk("tf_data", tf_data, q[0]);
                        chk("tf_last", DW'(tf_last), DW'(q.size() == 1));
                    end
                    if (!tf_ready) chk("stall_EN", DW'(rom_EN), DW'(0));
                    else if (q.size() > 0) begin
                        void'(q.pop_front());
                        acc++;
                    end
                end
                step();
                c++;
            end
        end
        ld_we = 1'b0;
        chk("done_seen", DW'(seen_done), DW'(1));
        chk("beats_left", DW'(q.size()), DW'(0));
        chk("tf_valid_at_done", DW'(tf_valid), DW'(0));
        if (rmode == 0) chk("done_cycle", DW'(c), DW'((ovf || num == 0) ? 0 : num + 1));
        if (rmode == 2) chk("stall_len", DW'(stl), DW'(stall_len));
        step();
        chk("done_pulse", DW'(done), DW'(0));
        chk("idle_busy", DW'(busy), DW'(0));
        chk("err", DW'(err), DW'(ref_err));
    endtask

    initial begin
        passes = 0; fails = 0; checks = 0;
        rst = 1'b1; start = 1'b0; mode_inv = 1'b0; base_addr = '0; num_rows = '0;
        ld_clr = 1'b0; ld_we = 1'b0; ld_data = '0; tf_ready = 1'b0;
        ref_ptr = 0; ref_err = 1'b0;
        step();
        step();
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_err", DW'(err), DW'(0));
        chk("rst_valid", DW'(tf_valid), DW'(0));
        chk("rst_last", DW'(tf_last), DW'(0));
        chk("rst_EN", DW'(rom_EN), DW'(0));
        chk("rst_REN", DW'(rom_REN), DW'(1));
        chk("rst_A", DW'(rom_A), DW'(0));
        chk("rst_D", rom_D, DW'(0));
        rst = 1'b0;
        step();

        // ld_clr wins over ld_we: no ROM write that cycle
        ld_clr = 1'b1; ld_we = 1'b1; #1;
        chk("clr_prio_EN", DW'(rom_EN), DW'(0));
        step();
        ld_clr = 1'b0; ld_we = 1'b0;
        ref_ptr = 0;

        for (int i = 0; i < DEPTH; i++) load(DW'(i), 1'b1);
        load(DW'(999), 1'b1);

        run_pass(10, 4, 1'b0, 0, 0, 0, 1'b0);
        run_pass(10, 4, 1'b1, 0, 0, 0, 1'b0);
        run_pass(10, 4, 1'b0, 2, 1, 3, 1'b0);

        run_pass(200, 20, 1'b0, 0, 0, 0, 1'b0);
        run_pass(5, 0, 1'b0, 0, 0, 0, 1'b0);
        clr();
        #1;
        chk("err_cleared", DW'(err), DW'(0));
        run_pass(5, 0, 1'b0, 0, 0, 0, 1'b0);
        run_pass(209, 4, 1'b1, 0, 0, 0, 1'b0);
        run_pass(212, 1, 1'b0, 0, 0, 0, 1'b0);
        run_pass(0, 4, 1'b0, 0, 0, 0, 1'b0);

        // reset in the middle of a pass, then replay from base
        tf_ready = 1'b1; start = 1'b1; base_addr = 8'd10; num_rows = 9'd4; mode_inv = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", DW'(tf_valid), DW'(0));
        chk("mid_rst_busy", DW'(busy), DW'(0));
        chk("mid_rst_EN", DW'(rom_EN), DW'(0));
        step();
        rst = 1'b0;
        ref_ptr = 0; ref_err = 1'b0;
        step();
        run_pass(10, 4, 1'b0, 0, 0, 0, 1'b0);

        // random contents and random windows with back-pressure and load noise
        clr();
        for (int i = 0; i < DEPTH; i++) load(DW'({$urandom(), $urandom(), $urandom()}), 1'b0);
        for (int p = 0; p < 25; p++) begin
            int b;
            int n;
            b = $urandom_range(0, DEPTH - 1);
            n = $urandom_range(0, 40);
            run_pass(b, n, ($urandom_range(0, 1) == 1), 1, 0, 0, 1'b1);
            if (ref_err && $urandom_range(0, 1) == 1) begin
                clr();
                #1;
                chk("rand_err_clr", DW'(err), DW'(0));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
